// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: captures fetched pc/instruction, holds on stall, inserts a NOP
// bubble on flush, and keeps saturating stall/flush event counters for performance debug.
module if_id_pipeline_register #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] NOP_INSN  = 32'h00000013,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          if_instruction,
    input  logic                 IF_ID_write,
    input  logic                 IF_ID_flush,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_instruction,
    output logic                 id_valid,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [XLEN-1:0]      pc_p1;
    logic [31:0]          insn_p1;
    logic                 vld_p1;
    logic [CNT_WIDTH-1:0] stall_cnt_p1;
    logic [CNT_WIDTH-1:0] flush_cnt_p1;

    // Counters stick at all-ones so a long run never reports a misleadingly small value.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // IF -> ID stage boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p1        <= '0;
            insn_p1      <= NOP_INSN;
            vld_p1       <= 1'b0;
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else if (IF_ID_flush) begin
            // Flush wins over a concurrent stall; the stall is not counted.
            pc_p1        <= if_pc;
            insn_p1      <= NOP_INSN;
            vld_p1       <= 1'b0;
            flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end else if (!IF_ID_write) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end else begin
            pc_p1        <= if_pc;
            insn_p1      <= if_instruction;
            vld_p1       <= 1'b1;
        end
    end

    assign id_pc          = pc_p1;
    assign id_instruction = insn_p1;
    assign id_valid       = vld_p1;
    assign stall_count    = stall_cnt_p1;
    assign flush_count    = flush_cnt_p1;

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Bench for if_id_pipeline_register: a full-width DUT and a 4-bit-counter DUT share stimulus
// and are compared every cycle against a behavioural model plus directed literal checks.
module tb_if_id_pipeline_register;

    localparam int          XLEN = 64;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] if_pc = '0;
    logic [31:0]     if_instruction = '0;
    logic            IF_ID_write = 1'b0;
    logic            IF_ID_flush = 1'b0;

    logic [XLEN-1:0] id_pc, s_id_pc;
    logic [31:0]     id_instruction, s_id_instruction;
    logic            id_valid, s_id_valid;
    logic [31:0]     stall_count, flush_count;
    logic [3:0]      s_stall_count, s_flush_count;

    int tests = 0;
    int fails = 0;

    if_id_pipeline_register #(.XLEN(XLEN), .NOP_INSN(NOP), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
        .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .id_pc(id_pc), .id_instruction(id_instruction), .id_valid(id_valid),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    if_id_pipeline_register #(.XLEN(XLEN), .NOP_INSN(NOP), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
        .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .id_pc(s_id_pc), .id_instruction(s_id_instruction), .id_valid(s_id_valid),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: unbounded event counts, saturation applied only when comparing.
    logic [XLEN-1:0] m_pc;
    logic [31:0]     m_insn;
    logic            m_valid;
    longint          m_stalls, m_flushes;
    bit              m_known = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = '0; m_insn = NOP; m_valid = 0; m_stalls = 0; m_flushes = 0; m_known = 1;
        end else if (m_known) begin
            if (IF_ID_flush) begin
                m_pc = if_pc; m_insn = NOP; m_valid = 0; m_flushes++;
            end else if (IF_ID_write) begin
                m_pc = if_pc; m_insn = if_instruction; m_valid = 1;
            end else begin
                m_stalls++;
            end
        end
    end

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            chk("cyc_pc",         id_pc,            m_pc);
            chk("cyc_insn",       id_instruction,   m_insn);
            chk("cyc_valid",      id_valid,         m_valid);
            chk("cyc_stall",      stall_count,      sat(m_stalls, 32'hFFFF_FFFF));
            chk("cyc_flush",      flush_count,      sat(m_flushes, 32'hFFFF_FFFF));
            chk("cyc_s_pc",       s_id_pc,          m_pc);
            chk("cyc_s_insn",     s_id_instruction, m_insn);
            chk("cyc_s_valid",    s_id_valid,       m_valid);
            chk("cyc_s_stall",    s_stall_count,    sat(m_stalls, 15));
            chk("cyc_s_flush",    s_flush_count,    sat(m_flushes, 15));
        end
    end

    // Apply one cycle of inputs, let one edge pass, return just after the following falling edge.
    task automatic cyc(input logic r, input logic fl, input logic wr,
                       input logic [XLEN-1:0] pc, input logic [31:0] insn);
        rst = r; IF_ID_flush = fl; IF_ID_write = wr; if_pc = pc; if_instruction = insn;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset for two cycles
        cyc(1, 0, 1, 64'h1234, 32'hDEAD_BEEF);
        cyc(1, 0, 1, 64'h5678, 32'hDEAD_BEEF);
        chk("rst_pc", id_pc, 64'h0);
        chk("rst_insn", id_instruction, 32'h00000013);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_flush", flush_count, 32'd0);

        // 1: first edge after reset is a load
        cyc(0, 0, 1, 64'h0, 32'h00500093);
        chk("t1_pc", id_pc, 64'h0);
        chk("t1_insn", id_instruction, 32'h00500093);
        chk("t1_valid", id_valid, 1'b1);
        chk("t1_stall", stall_count, 32'd0);

        // 2: load then stall three cycles
        cyc(0, 0, 1, 64'h4, 32'h00A00113);
        cyc(0, 0, 0, 64'h8, 32'h11111111);
        cyc(0, 0, 0, 64'hC, 32'h22222222);
        cyc(0, 0, 0, 64'h10, 32'h33333333);
        chk("t2_pc", id_pc, 64'h4);
        chk("t2_insn", id_instruction, 32'h00A00113);
        chk("t2_valid", id_valid, 1'b1);
        chk("t2_stall", stall_count, 32'd3);

        // 3: flush concurrent with stall
        cyc(0, 1, 0, 64'h40, 32'h44444444);
        chk("t3_insn", id_instruction, 32'h00000013);
        chk("t3_valid", id_valid, 1'b0);
        chk("t3_pc", id_pc, 64'h40);
        chk("t3_flush", flush_count, 32'd1);
        chk("t3_stall", stall_count, 32'd3);

        // 4: back-to-back load after flush
        cyc(0, 0, 1, 64'h44, 32'h00308193);
        chk("t4_valid", id_valid, 1'b1);
        chk("t4_pc", id_pc, 64'h44);
        chk("t4_insn", id_instruction, 32'h00308193);

        // Held bubble stays invalid; flush with write=1 still squashes
        cyc(0, 1, 1, 64'h80, 32'h55555555);
        cyc(0, 0, 0, 64'h84, 32'h66666666);
        cyc(0, 0, 0, 64'h88, 32'h77777777);
        chk("bub_valid", id_valid, 1'b0);
        chk("bub_insn", id_instruction, 32'h00000013);
        chk("bub_pc", id_pc, 64'h80);
        chk("bub_stall", stall_count, 32'd5);
        chk("bub_flush", flush_count, 32'd2);
        cyc(0, 0, 1, 64'h84, 32'h00400213);
        chk("bub_reload", id_valid, 1'b1);

        // 6: reset in the middle of a stall (with a flush request too)
        cyc(1, 0, 0, 64'h0, 32'h0);
        cyc(0, 0, 1, 64'h100, 32'h00100093);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 64'h104 + 64'(4 * i), 32'h0);
        chk("t6_pre_stall", stall_count, 32'd5);
        cyc(1, 1, 0, 64'h200, 32'h99999999);
        chk("t6_pc", id_pc, 64'h0);
        chk("t6_insn", id_instruction, 32'h00000013);
        chk("t6_valid", id_valid, 1'b0);
        chk("t6_stall", stall_count, 32'd0);
        chk("t6_flush", flush_count, 32'd0);

        // 5: saturation of the 4-bit stall counter
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 64'(i), 32'h0);
            if (i == 14) chk("t5_reach_f", s_stall_count, 4'hF);
        end
        chk("t5_sat", s_stall_count, 4'hF);
        chk("t5_wide", stall_count, 32'd20);
        chk("t5_valid", id_valid, 1'b0);

        // 4-bit flush counter saturation
        for (int i = 0; i < 18; i++) cyc(0, 1, 1, 64'(i), 32'h0);
        chk("fsat_small", s_flush_count, 4'hF);
        chk("fsat_wide", flush_count, 32'd18);
        chk("fsat_stall", s_stall_count, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
